// File: rtl/fetch_decode_pipe_unit.sv
// -----------------------------------------------------------------------------
// fetch_decode_pipe_unit
//   Fetch-to-decode pipeline register backed by a one-entry skid buffer. Words
//   returned by the synchronous instruction memory are captured here and handed
//   to decode in strict FIFO order. A word that arrives while decode stalls
//   goes into the skid buffer, so nothing in flight is lost. A flush from
//   execute squashes everything held and replaces it with a NOP bubble.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   stall               decode cannot take the presented word this cycle
//   flush               squash all held words (taken branch/jump)
//   fetch_valid         instruction_fetch / PC_fetch carry a word
//   instruction_fetch   instruction word from instruction memory
//   PC_fetch            PC of instruction_fetch
//   fetch_ready         a word can be accepted this cycle (registered state only)
//   instruction_decode  word presented to decode (NOP_INST when not valid)
//   PC_decode           PC of instruction_decode
//   valid_decode        instruction_decode is a real instruction
//   overflow_error      sticky: fetch_valid seen while fetch_ready was low
//   flush_count         saturating count of valid words squashed by flush
//
// FLUSH_COUNT_INIT is the reset value of flush_count. It defaults to zero and
// lets the saturation logic be exercised without 64k flushes.
// -----------------------------------------------------------------------------
module fetch_decode_pipe_unit #(
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    ADDRESS_BITS     = 20,
    parameter logic [DATA_WIDTH-1:0] NOP_INST         = 32'h00000013,
    parameter logic [15:0]           FLUSH_COUNT_INIT = 16'h0000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    fetch_valid,
    input  logic [DATA_WIDTH-1:0]   instruction_fetch,
    input  logic [ADDRESS_BITS-1:0] PC_fetch,
    output logic                    fetch_ready,
    output logic [DATA_WIDTH-1:0]   instruction_decode,
    output logic [ADDRESS_BITS-1:0] PC_decode,
    output logic                    valid_decode,
    output logic                    overflow_error,
    output logic [15:0]             flush_count
);

    // EMPTY: nothing held. ONE: output register valid. FULL: output + skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   out_inst, out_inst_next;
    logic [ADDRESS_BITS-1:0] out_pc, out_pc_next;
    logic [DATA_WIDTH-1:0]   skid_inst, skid_inst_next;
    logic [ADDRESS_BITS-1:0] skid_pc, skid_pc_next;
    logic                    overflow, overflow_next;
    logic [15:0]             squashed, squashed_next;

    logic                    consume;
    logic                    accept;
    logic [1:0]              held;
    logic [16:0]             squashed_sum;

    // Ready and valid come straight from the state register, so there is no
    // combinational path from stall/flush to fetch_ready.
    assign fetch_ready        = (state != FULL);
    assign valid_decode       = (state != EMPTY);
    assign instruction_decode = out_inst;
    assign PC_decode          = out_pc;
    assign overflow_error     = overflow;
    assign flush_count        = squashed;

    assign consume = valid_decode & ~stall;
    assign accept  = fetch_valid & fetch_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_next     = state;
        out_inst_next  = out_inst;
        out_pc_next    = out_pc;
        skid_inst_next = skid_inst;
        skid_pc_next   = skid_pc;
        overflow_next  = overflow;
        squashed_next  = squashed;
        held           = 2'd0;

        // A word offered while not ready is dropped; remember that it happened.
        if (fetch_valid && !fetch_ready) begin
            overflow_next = 1'b1;
        end

        unique case (state)
            ONE:     held = 2'd1;
            FULL:    held = 2'd2;
            default: held = 2'd0;
        endcase
        squashed_sum = {1'b0, squashed} + 17'(held);

        if (flush) begin
            // Squash everything; the word offered this cycle is discarded too.
            state_next    = EMPTY;
            out_inst_next = NOP_INST;
            squashed_next = squashed_sum[16] ? 16'hFFFF : squashed_sum[15:0];
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        out_inst_next = instruction_fetch;
                        out_pc_next   = PC_fetch;
                        state_next    = ONE;
                    end
                end
                ONE: begin
                    if (consume && accept) begin
                        out_inst_next = instruction_fetch;
                        out_pc_next   = PC_fetch;
                    end else if (consume) begin
                        // Drained: bubble to decode, PC of the last word stays.
                        out_inst_next = NOP_INST;
                        state_next    = EMPTY;
                    end else if (accept) begin
                        skid_inst_next = instruction_fetch;
                        skid_pc_next   = PC_fetch;
                        state_next     = FULL;
                    end
                end
                FULL: begin
                    if (consume) begin
                        out_inst_next = skid_inst;
                        out_pc_next   = skid_pc;
                        state_next    = ONE;
                    end
                end
                default: begin
                    state_next    = EMPTY;
                    out_inst_next = NOP_INST;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the skid buffer is only two registers, so it is cleared with
            // the rest of the state; held words must never survive a reset.
            state     <= EMPTY;
            out_inst  <= NOP_INST;
            out_pc    <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
            overflow  <= 1'b0;
            squashed  <= FLUSH_COUNT_INIT;
        end else begin
            state     <= state_next;
            out_inst  <= out_inst_next;
            out_pc    <= out_pc_next;
            skid_inst <= skid_inst_next;
            skid_pc   <= skid_pc_next;
            overflow  <= overflow_next;
            squashed  <= squashed_next;
        end
    end

endmodule

// File: tb/tb_fetch_decode_pipe_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_pipe_unit
//   Self-checking bench. Every accepted word is pushed into a scoreboard queue
//   and popped when decode consumes it; the head of the queue is the word the
//   DUT must present. A second instance with flush_count preloaded near its
//   limit shares all inputs and checks the saturation.
// -----------------------------------------------------------------------------
module tb_fetch_decode_pipe_unit;

    localparam int          DW  = 32;
    localparam int          AW  = 20;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [15:0] SAT_INIT = 16'hFFFE;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall, flush, fetch_valid;
    logic [DW-1:0] instruction_fetch;
    logic [AW-1:0] PC_fetch;

    logic          fetch_ready, valid_decode, overflow_error;
    logic [DW-1:0] instruction_decode;
    logic [AW-1:0] PC_decode;
    logic [15:0]   flush_count;

    logic          sat_fetch_ready, sat_valid_decode, sat_overflow_error;
    logic [DW-1:0] sat_instruction_decode;
    logic [AW-1:0] sat_PC_decode;
    logic [15:0]   sat_flush_count;

    always #5 clock = ~clock;

    fetch_decode_pipe_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NOP_INST(NOP)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .fetch_valid(fetch_valid), .instruction_fetch(instruction_fetch), .PC_fetch(PC_fetch),
        .fetch_ready(fetch_ready), .instruction_decode(instruction_decode), .PC_decode(PC_decode),
        .valid_decode(valid_decode), .overflow_error(overflow_error), .flush_count(flush_count)
    );

    fetch_decode_pipe_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NOP_INST(NOP),
                             .FLUSH_COUNT_INIT(SAT_INIT)) dut_sat (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .fetch_valid(fetch_valid), .instruction_fetch(instruction_fetch), .PC_fetch(PC_fetch),
        .fetch_ready(sat_fetch_ready), .instruction_decode(sat_instruction_decode),
        .PC_decode(sat_PC_decode), .valid_decode(sat_valid_decode),
        .overflow_error(sat_overflow_error), .flush_count(sat_flush_count)
    );

    typedef struct packed {
        logic [DW-1:0] inst;
        logic [AW-1:0] pc;
    } word_t;

    word_t       sb_q[$];
    int unsigned m_cnt;
    bit          m_ovf;
    logic [AW-1:0] m_pc;
    bit          pc_known;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_cnt    = 0;
        m_ovf    = 1'b0;
        m_pc     = '0;
        pc_known = 1'b1;
    endtask

    task automatic compare_outputs();
        int unsigned sat_exp;
        check("valid_decode", 64'(valid_decode), 64'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check("instruction_decode", 64'(instruction_decode), 64'(sb_q[0].inst));
            check("PC_decode", 64'(PC_decode), 64'(sb_q[0].pc));
        end else begin
            check("nop_decode", 64'(instruction_decode), 64'(NOP));
            if (pc_known) check("PC_hold", 64'(PC_decode), 64'(m_pc));
        end
        check("fetch_ready", 64'(fetch_ready), 64'(sb_q.size() < 2));
        check("overflow_error", 64'(overflow_error), 64'(m_ovf));
        check("flush_count", 64'(flush_count), 64'(m_cnt));
        sat_exp = 32'(SAT_INIT) + m_cnt;
        if (sat_exp > 32'hFFFF) sat_exp = 32'hFFFF;
        check("flush_count_sat", 64'(sat_flush_count), 64'(sat_exp));
    endtask

    // Drive one cycle of stimulus, advance the scoreboard across the edge and
    // compare the DUT outputs #1 after that edge.
    task automatic step(input bit s, input bit f, input bit v,
                        input logic [DW-1:0] i, input logic [AW-1:0] p);
        int sz;
        stall             = s;
        flush             = f;
        fetch_valid       = v;
        instruction_fetch = i;
        PC_fetch          = p;
        @(posedge clock);
        #1;
        sz = sb_q.size();
        if (v && sz == 2) m_ovf = 1'b1;
        if (f) begin
            m_cnt = m_cnt + sz;
            if (m_cnt > 32'hFFFF) m_cnt = 32'hFFFF;
            sb_q.delete();
            pc_known = 1'b0;
        end else begin
            if (sz > 0 && !s) void'(sb_q.pop_front());
            if (v && sz < 2) sb_q.push_back({i, p});
        end
        if (sb_q.size() != 0) begin
            m_pc     = sb_q[0].pc;
            pc_known = 1'b1;
        end
        compare_outputs();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
        instruction_fetch = '0; PC_fetch = '0;
        model_reset();
        #12;
        compare_outputs();
        reset = 1'b0;

        // Back-to-back stream, no stall.
        step(0, 0, 1, 32'h00500093, 20'd0);
        step(0, 0, 1, 32'h00A00113, 20'd4);

        // Stall absorb into the skid buffer, then release.
        step(1, 0, 1, 32'h002081B3, 20'd8);
        step(1, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        // Drain: bubble with PC held.
        step(0, 0, 0, '0, '0);
        check("drain_pc", 64'(PC_decode), 64'(20'd8));

        // Protocol error: offer a word while FULL, then more while draining.
        step(1, 0, 1, 32'h11111111, 20'd12);
        step(1, 0, 1, 32'h22222222, 20'd16);
        step(1, 0, 1, 32'h33333333, 20'd20);
        step(0, 0, 1, 32'h44444444, 20'd24);
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);

        // Flush in FULL with a word offered, in ONE, and in EMPTY.
        step(1, 0, 1, 32'h55555555, 20'd28);
        step(1, 0, 1, 32'h66666666, 20'd32);
        step(1, 1, 1, 32'h77777777, 20'd36);
        step(0, 0, 0, '0, '0);
        step(0, 0, 1, 32'h88888888, 20'd40);
        step(0, 0, 0, '0, '0);
        step(1, 0, 1, 32'h99999999, 20'd44);
        step(0, 1, 0, '0, '0);
        step(0, 1, 1, 32'hAAAAAAAA, 20'd48);
        step(0, 0, 0, '0, '0);

        // Random traffic with occasional flushes.
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 1, $urandom, AW'(100 + 4 * k));
        end

        // Asynchronous reset between edges while FULL.
        step(0, 1, 0, '0, '0);
        step(1, 0, 1, 32'hBBBBBBBB, 20'd60);
        step(1, 0, 1, 32'hCCCCCCCC, 20'd64);
        stall = 1'b0; fetch_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        #1;
        reset = 1'b0;
        step(0, 0, 1, 32'hDDDDDDDD, 20'd68);
        step(0, 0, 0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
